// File: rtl/trig_out_ctrl_if.sv
// Bus bundle for trig_out_ctrl: trigger sources, arming/config inputs and pulse/status outputs.
// The parameters must match the trig_out_ctrl instance that uses this bundle.
interface trig_out_ctrl_if #(
    parameter int pNUM_SRC = 4,
    parameter int pDELAY_W = 16,
    parameter int pWIDTH_W = 16,
    parameter int pCOUNT_W = 16
);
    localparam int SEL_W = (pNUM_SRC > 1) ? $clog2(pNUM_SRC) : 1;

    logic [pNUM_SRC-1:0] I_trig_src;
    logic [pNUM_SRC-1:0] I_src_mask;
    logic [1:0]          I_mode;
    logic [SEL_W-1:0]    I_sel;
    logic [pDELAY_W-1:0] I_delay;
    logic [pWIDTH_W-1:0] I_pulse_width;
    logic                I_arm;
    logic                I_oneshot;
    logic                O_trig_out;
    logic                O_armed;
    logic                O_busy;
    logic [pCOUNT_W-1:0] O_fired;
    logic [pCOUNT_W-1:0] O_missed;
    logic                O_led;

    modport master (
        output I_trig_src, I_src_mask, I_mode, I_sel, I_delay, I_pulse_width, I_arm, I_oneshot,
        input  O_trig_out, O_armed, O_busy, O_fired, O_missed, O_led
    );

    modport slave (
        input  I_trig_src, I_src_mask, I_mode, I_sel, I_delay, I_pulse_width, I_arm, I_oneshot,
        output O_trig_out, O_armed, O_busy, O_fired, O_missed, O_led
    );
endinterface

// File: rtl/trig_out_ctrl.sv
// Trigger-output controller: masked OR/AND/passthru combine of sources, then a delayed,
// width-programmed pulse on trig_out, with fired/missed counters and a heartbeat LED.
module trig_out_ctrl #(
    parameter int pNUM_SRC = 4,
    parameter int pSYNC    = 1,
    parameter int pDELAY_W = 16,
    parameter int pWIDTH_W = 16,
    parameter int pCOUNT_W = 16,
    parameter int pLED_W   = 23
) (
    input logic            trace_clk,
    input logic            resetn,
    trig_out_ctrl_if.slave bus
);
    localparam int SEL_W = (pNUM_SRC > 1) ? $clog2(pNUM_SRC) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_DELAY, ST_PULSE, ST_DONE} state_e;

    logic [pNUM_SRC-1:0] s;

    generate
        if (pSYNC != 0) begin : g_sync
            logic [pNUM_SRC-1:0] meta_q, sync_q;
            always_ff @(posedge trace_clk or negedge resetn) begin
                if (!resetn) begin
                    meta_q <= '0;
                    sync_q <= '0;
                end else begin
                    meta_q <= bus.I_trig_src;
                    sync_q <= meta_q;
                end
            end
            assign s = sync_q;
        end else begin : g_nosync
            assign s = bus.I_trig_src;
        end
    endgenerate

    state_e              state_q, state_d;
    logic                cond_q, cond_d;
    logic                arm_q, arm_d;
    logic [pNUM_SRC-1:0] mask_q, mask_d;
    logic [1:0]          mode_q, mode_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [pDELAY_W-1:0] delay_q, delay_d, dcnt_q, dcnt_d;
    logic [pWIDTH_W-1:0] width_q, width_d, wcnt_q, wcnt_d;
    logic                oneshot_q, oneshot_d;
    logic                trig_q, trig_d;
    logic                armed_q, armed_d;
    logic                busy_q, busy_d;
    logic [pCOUNT_W-1:0] fired_q, fired_d, missed_q, missed_d;
    logic [pLED_W-1:0]   led_q, led_d;

    logic [pNUM_SRC-1:0] cfg_mask;
    logic [1:0]          cfg_mode;
    logic                comb, src_edge, fired_inc, missed_inc;
    logic [pWIDTH_W-1:0] width_eff;

    always_comb begin
        // In IDLE the live config drives the condition so cond_q is already
        // tracking when ARMED is entered; a pre-existing high level cannot fire.
        cfg_mask = (state_q == ST_IDLE) ? bus.I_src_mask : mask_q;
        cfg_mode = (state_q == ST_IDLE) ? bus.I_mode     : mode_q;
        if (cfg_mode == 2'd1)
            comb = (cfg_mask != '0) && (&(s | ~cfg_mask));
        else
            comb = |(s & cfg_mask);
        src_edge  = comb & ~cond_q;
        width_eff = (width_q == '0) ? pWIDTH_W'(1) : width_q;

        state_d    = state_q;
        cond_d     = comb;
        arm_d      = bus.I_arm;
        mask_d     = mask_q;
        mode_d     = mode_q;
        sel_d      = sel_q;
        delay_d    = delay_q;
        width_d    = width_q;
        oneshot_d  = oneshot_q;
        dcnt_d     = dcnt_q;
        wcnt_d     = wcnt_q;
        trig_d     = 1'b0;
        fired_inc  = 1'b0;
        missed_inc = 1'b0;

        if (state_q == ST_IDLE) begin
            mask_d    = bus.I_src_mask;
            mode_d    = bus.I_mode;
            sel_d     = bus.I_sel;
            delay_d   = bus.I_delay;
            width_d   = bus.I_pulse_width;
            oneshot_d = bus.I_oneshot;
        end

        if (!bus.I_arm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (mode_q == 2'd2) begin
                        trig_d    = s[sel_q];
                        fired_inc = s[sel_q] & ~trig_q;
                    end else if (src_edge) begin
                        if (delay_q == '0) begin
                            state_d   = ST_PULSE;
                            trig_d    = 1'b1;
                            wcnt_d    = width_eff;
                            fired_inc = 1'b1;
                        end else begin
                            state_d = ST_DELAY;
                            dcnt_d  = delay_q;
                        end
                    end
                end
                ST_DELAY: begin
                    missed_inc = src_edge;
                    if (dcnt_q == pDELAY_W'(1)) begin
                        state_d   = ST_PULSE;
                        trig_d    = 1'b1;
                        wcnt_d    = width_eff;
                        fired_inc = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q - pDELAY_W'(1);
                    end
                end
                ST_PULSE: begin
                    missed_inc = src_edge;
                    if (wcnt_q == pWIDTH_W'(1)) begin
                        state_d = oneshot_q ? ST_DONE : ST_ARMED;
                    end else begin
                        wcnt_d = wcnt_q - pWIDTH_W'(1);
                        trig_d = 1'b1;
                    end
                end
                ST_DONE:  missed_inc = src_edge;
                default:  state_d = ST_IDLE;
            endcase
        end

        fired_d  = fired_q;
        missed_d = missed_q;
        if (bus.I_arm && !arm_q) begin
            fired_d  = '0;
            missed_d = '0;
        end else begin
            if (fired_inc && (fired_q != '1))   fired_d  = fired_q + pCOUNT_W'(1);
            if (missed_inc && (missed_q != '1)) missed_d = missed_q + pCOUNT_W'(1);
        end

        armed_d = (state_d == ST_ARMED);
        busy_d  = (state_d == ST_DELAY) || (state_d == ST_PULSE);
        led_d   = trig_q ? led_q : led_q + pLED_W'(1);
    end

    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cond_q    <= 1'b0;
            arm_q     <= 1'b0;
            mask_q    <= '0;
            mode_q    <= '0;
            sel_q     <= '0;
            delay_q   <= '0;
            width_q   <= '0;
            oneshot_q <= 1'b0;
            dcnt_q    <= '0;
            wcnt_q    <= '0;
            trig_q    <= 1'b0;
            armed_q   <= 1'b0;
            busy_q    <= 1'b0;
            fired_q   <= '0;
            missed_q  <= '0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            cond_q    <= cond_d;
            arm_q     <= arm_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            sel_q     <= sel_d;
            delay_q   <= delay_d;
            width_q   <= width_d;
            oneshot_q <= oneshot_d;
            dcnt_q    <= dcnt_d;
            wcnt_q    <= wcnt_d;
            trig_q    <= trig_d;
            armed_q   <= armed_d;
            busy_q    <= busy_d;
            fired_q   <= fired_d;
            missed_q  <= missed_d;
            led_q     <= led_d;
        end
    end

    assign bus.O_trig_out = trig_q;
    assign bus.O_armed    = armed_q;
    assign bus.O_busy     = busy_q;
    assign bus.O_fired    = fired_q;
    assign bus.O_missed   = missed_q;
    assign bus.O_led      = led_q[pLED_W-1];
endmodule

// File: tb/tb_trig_out_ctrl.sv
// Directed bench for trig_out_ctrl: sources unsynchronised, 4-bit counters and a 4-bit
// heartbeat so saturation and the LED freeze show up in a short run.
module tb_trig_out_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] led_m;

    always #5 clk = ~clk;

    trig_out_ctrl_if #(.pNUM_SRC(4), .pDELAY_W(16), .pWIDTH_W(16), .pCOUNT_W(4)) bus ();

    trig_out_ctrl #(
        .pNUM_SRC(4), .pSYNC(0), .pDELAY_W(16), .pWIDTH_W(16), .pCOUNT_W(4), .pLED_W(4)
    ) dut (
        .trace_clk(clk),
        .resetn   (rst_n),
        .bus      (bus)
    );

    // heartbeat reference: advances on every cycle the pulse output is low
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_m <= '0;
        else if (!bus.O_trig_out) led_m <= led_m + 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [1:0] mode, input logic [3:0] mask, input logic [15:0] dly,
                         input logic [15:0] wid, input logic os, input logic [1:0] sel);
        bus.I_arm = 1'b0;
        tick();
        tick();
        bus.I_mode = mode;
        bus.I_src_mask = mask;
        bus.I_delay = dly;
        bus.I_pulse_width = wid;
        bus.I_oneshot = os;
        bus.I_sel = sel;
        bus.I_arm = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.I_trig_src = '0; bus.I_src_mask = '0; bus.I_mode = '0; bus.I_sel = '0;
        bus.I_delay = '0; bus.I_pulse_width = '0; bus.I_arm = 1'b0; bus.I_oneshot = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({bus.O_trig_out, bus.O_armed, bus.O_busy, bus.O_fired, bus.O_missed, bus.O_led} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {bus.O_trig_out, bus.O_armed, bus.O_busy, bus.O_fired, bus.O_missed, bus.O_led});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_or_pulse();
        logic [4:0] exp_trig = 5'b00111;
        setup(2'd0, 4'b0011, 16'd0, 16'd3, 1'b0, 2'd0);
        n_tests++;
        if (bus.O_armed !== 1'b1) begin n_fail++; $display("FAIL or_armed: got %b want 1", bus.O_armed); end
        for (int c = 0; c < 5; c++) begin
            bus.I_trig_src[1] = (c == 0);
            tick();
            n_tests++;
            if (bus.O_trig_out !== exp_trig[c]) begin
                n_fail++;
                $display("FAIL or_trig[%0d]: got %b want %b", c + 1, bus.O_trig_out, exp_trig[c]);
            end
        end
        n_tests++;
        if (bus.O_fired !== 4'd1 || bus.O_missed !== 4'd0) begin
            n_fail++;
            $display("FAIL or_counts: got fired=%0d missed=%0d want 1/0", bus.O_fired, bus.O_missed);
        end
    endtask

    task automatic test_delay();
        setup(2'd0, 4'b0011, 16'd5, 16'd1, 1'b0, 2'd0);
        for (int c = 0; c < 10; c++) begin
            bus.I_trig_src[0] = (c == 0) || (c == 2);
            tick();
            n_tests++;
            if (bus.O_trig_out !== (c + 1 == 6)) begin
                n_fail++;
                $display("FAIL delay_trig[%0d]: got %b want %b", c + 1, bus.O_trig_out, (c + 1 == 6));
            end
            if (c == 0) begin
                n_tests++;
                if (bus.O_busy !== 1'b1) begin n_fail++; $display("FAIL delay_busy: got %b want 1", bus.O_busy); end
            end
        end
        n_tests++;
        if (bus.O_fired !== 4'd1 || bus.O_missed !== 4'd1) begin
            n_fail++;
            $display("FAIL delay_counts: got fired=%0d missed=%0d want 1/1", bus.O_fired, bus.O_missed);
        end
    endtask

    task automatic test_and();
        bus.I_trig_src = 4'b0001;
        setup(2'd1, 4'b0101, 16'd0, 16'd1, 1'b0, 2'd0);
        bus.I_trig_src[2] = 1'b1;
        tick();
        n_tests++;
        if (bus.O_trig_out !== 1'b1) begin n_fail++; $display("FAIL and_fire: got %b want 1", bus.O_trig_out); end
        tick();
        bus.I_trig_src[2] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.I_trig_src[0] = (c != 1);
            tick();
            n_tests++;
            if (bus.O_trig_out !== 1'b0) begin n_fail++; $display("FAIL and_src0_only[%0d]: got %b want 0", c, bus.O_trig_out); end
        end
        n_tests++;
        if (bus.O_fired !== 4'd1) begin n_fail++; $display("FAIL and_fired: got %0d want 1", bus.O_fired); end
        bus.I_trig_src = '0;
        setup(2'd1, 4'b0000, 16'd0, 16'd1, 1'b0, 2'd0);
        for (int c = 0; c < 4; c++) begin
            bus.I_trig_src = (c[0] == 1'b0) ? 4'hF : 4'h0;
            tick();
            n_tests++;
            if (bus.O_trig_out !== 1'b0) begin n_fail++; $display("FAIL and_mask0[%0d]: got %b want 0", c, bus.O_trig_out); end
        end
        n_tests++;
        if (bus.O_fired !== 4'd0) begin n_fail++; $display("FAIL and_mask0_fired: got %0d want 0", bus.O_fired); end
        bus.I_trig_src = '0;
    endtask

    task automatic test_oneshot();
        setup(2'd0, 4'b0011, 16'd0, 16'd1, 1'b1, 2'd0);
        for (int e = 0; e < 3; e++) begin
            bus.I_trig_src[0] = 1'b1;
            tick();
            n_tests++;
            if (bus.O_trig_out !== (e == 0)) begin
                n_fail++;
                $display("FAIL oneshot_trig[%0d]: got %b want %b", e, bus.O_trig_out, (e == 0));
            end
            bus.I_trig_src[0] = 1'b0;
            repeat (19) tick();
        end
        n_tests++;
        if (bus.O_fired !== 4'd1 || bus.O_missed !== 4'd2) begin
            n_fail++;
            $display("FAIL oneshot_counts: got fired=%0d missed=%0d want 1/2", bus.O_fired, bus.O_missed);
        end
        bus.I_arm = 1'b0;
        tick();
        n_tests++;
        if (bus.O_fired !== 4'd1 || bus.O_missed !== 4'd2 || bus.O_armed !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_hold: got fired=%0d missed=%0d armed=%b want 1/2/0", bus.O_fired, bus.O_missed, bus.O_armed);
        end
        bus.I_arm = 1'b1;
        tick();
        n_tests++;
        if (bus.O_fired !== 4'd0 || bus.O_missed !== 4'd0 || bus.O_armed !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_rearm: got fired=%0d missed=%0d armed=%b want 0/0/1", bus.O_fired, bus.O_missed, bus.O_armed);
        end
        bus.I_trig_src[0] = 1'b1;
        tick();
        bus.I_trig_src[0] = 1'b0;
        n_tests++;
        if (bus.O_trig_out !== 1'b1 || bus.O_fired !== 4'd1) begin
            n_fail++;
            $display("FAIL oneshot_refire: got trig=%b fired=%0d want 1/1", bus.O_trig_out, bus.O_fired);
        end
        tick();
    endtask

    task automatic test_abort();
        setup(2'd0, 4'b0001, 16'd0, 16'd100, 1'b0, 2'd0);
        bus.I_trig_src[0] = 1'b1;
        tick();
        n_tests++;
        if (bus.O_trig_out !== 1'b1 || bus.O_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_start: got trig=%b busy=%b want 1/1", bus.O_trig_out, bus.O_busy);
        end
        repeat (9) tick();
        bus.I_arm = 1'b0;
        tick();
        n_tests++;
        if (bus.O_trig_out !== 1'b0 || bus.O_armed !== 1'b0 || bus.O_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_drop: got trig=%b armed=%b busy=%b want 0/0/0", bus.O_trig_out, bus.O_armed, bus.O_busy);
        end
        tick();
        bus.I_arm = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (bus.O_trig_out !== 1'b0) begin n_fail++; $display("FAIL abort_held_src[%0d]: got %b want 0", c, bus.O_trig_out); end
        end
        n_tests++;
        if (bus.O_fired !== 4'd0 || bus.O_armed !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rearm: got fired=%0d armed=%b want 0/1", bus.O_fired, bus.O_armed);
        end
        bus.I_trig_src = '0;
        tick();
    endtask

    task automatic test_passthru();
        logic [11:0] pat = 12'b001101110010;
        logic        led0;
        logic        frozen_ok;
        setup(2'd2, 4'b0000, 16'd0, 16'd1, 1'b0, 2'd2);
        for (int c = 0; c < 12; c++) begin
            bus.I_trig_src[2] = pat[c];
            bus.I_trig_src[0] = ~pat[c];
            tick();
            n_tests++;
            if (bus.O_trig_out !== pat[c]) begin
                n_fail++;
                $display("FAIL pass_trig[%0d]: got %b want %b", c, bus.O_trig_out, pat[c]);
            end
        end
        n_tests++;
        if (bus.O_fired !== 4'd3 || bus.O_missed !== 4'd0 || bus.O_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_counts: got fired=%0d missed=%0d busy=%b want 3/0/0", bus.O_fired, bus.O_missed, bus.O_busy);
        end
        bus.I_trig_src = 4'b0100;
        tick();
        led0 = bus.O_led;
        frozen_ok = 1'b1;
        repeat (20) begin
            tick();
            if (bus.O_led !== led0) frozen_ok = 1'b0;
        end
        n_tests++;
        if (frozen_ok !== 1'b1) begin n_fail++; $display("FAIL led_frozen: got changed want held at %b", led0); end
        bus.I_trig_src = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_tests++;
            if (bus.O_led !== led_m[3]) begin
                n_fail++;
                $display("FAIL led_run[%0d]: got %b want %b", c, bus.O_led, led_m[3]);
            end
        end
    endtask

    task automatic test_width_zero();
        logic [2:0] exp_trig = 3'b001;
        setup(2'd0, 4'b0001, 16'd0, 16'd0, 1'b0, 2'd0);
        for (int c = 0; c < 3; c++) begin
            bus.I_trig_src[0] = (c == 0);
            tick();
            n_tests++;
            if (bus.O_trig_out !== exp_trig[c]) begin
                n_fail++;
                $display("FAIL width0_trig[%0d]: got %b want %b", c + 1, bus.O_trig_out, exp_trig[c]);
            end
        end
    endtask

    task automatic test_saturation();
        setup(2'd0, 4'b0001, 16'd0, 16'd1, 1'b0, 2'd0);
        repeat (19) begin
            bus.I_trig_src[0] = 1'b1;
            tick();
            bus.I_trig_src[0] = 1'b0;
            tick();
            tick();
        end
        n_tests++;
        if (bus.O_fired !== 4'hF || bus.O_missed !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_fired: got fired=%0d missed=%0d want 15/0", bus.O_fired, bus.O_missed);
        end
    endtask

    initial begin
        test_reset();
        test_or_pulse();
        test_delay();
        test_and();
        test_oneshot();
        test_abort();
        test_passthru();
        test_width_zero();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
